// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter in front of a single-port synchronous RAM
//
// Purpose:
//   Serialises accesses from two requesters onto one single-port synchronous
//   RAM. Each transaction takes exactly three cycles: IDLE (arbitrate and
//   register the winner's command), ACCESS (RAM sees the command and write
//   enable), and COMPLETE (owner gets a one-cycle ack, rdata = RAM output).
//
// Configuration:
//   MEM_ARB_RR_EN defined   : round-robin on contention; the port not granted
//                             last wins. The last-grant register resets to
//                             port 1, so port 0 wins the first contention.
//   MEM_ARB_RR_EN undefined : fixed priority, port 0 always wins contention.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   req0/req1              request, held high until the matching ack
//   we0/we1                1 = write, 0 = read; stable while req is high
//   addr0/addr1            word address; stable while req is high
//   wdata0/wdata1          write data; stable while req is high
//   gnt0/gnt1              port owns the memory (ACCESS and COMPLETE)
//   ack0/ack1              one-cycle completion pulse to the owner
//   rdata                  read data, meaningful only while an ack is high
//   mem_addr/mem_din       registered RAM address / write data
//   mem_write              registered RAM write enable (ACCESS only)
//   mem_dout               RAM read data, valid one edge after mem_addr
//   busy                   high whenever the FSM is not in IDLE

module mem_arbiter #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              ack0,
   output logic              ack1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_dout,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ACCESS   = 2'd1,
      ST_COMPLETE = 2'd2
   } state_t;

   state_t              state_q,     state_d;
   logic                owner_q,     owner_d;     // 0 = port 0, 1 = port 1
   logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0]   mem_din_q,   mem_din_d;
   logic                mem_write_q, mem_write_d;
   logic                win_port;

`ifdef MEM_ARB_RR_EN
   logic                last_q,      last_d;      // port granted most recently

   // Contention goes to the port that did not win last time.
   always_comb begin
      win_port = 1'b0;
      if (req0 && req1) begin
         win_port = ~last_q;
      end else begin
         win_port = ~req0;
      end
   end
`else
   // Port 0 wins whenever it is requesting; port 1 only when port 0 is quiet.
   always_comb begin
      win_port = ~req0;
   end
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      // Write enable is only ever high for the single ACCESS cycle.
      mem_write_d = 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d      = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req0 || req1) begin
               owner_d     = win_port;
               mem_addr_d  = win_port ? addr1  : addr0;
               mem_din_d   = win_port ? wdata1 : wdata0;
               mem_write_d = win_port ? we1    : we0;
`ifdef MEM_ARB_RR_EN
               last_d      = win_port;
`endif
               state_d     = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            state_d = ST_COMPLETE;
         end
         ST_COMPLETE: begin
            // Requests are not sampled here; a held req starts a new
            // transaction from the following IDLE cycle.
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
         mem_write_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         mem_write_q <= mem_write_d;
`ifdef MEM_ARB_RR_EN
         last_q      <= last_d;
`endif
      end
   end

   logic owned;
   logic completing;

   assign owned      = (state_q != ST_IDLE);
   assign completing = (state_q == ST_COMPLETE);

   assign gnt0      = owned & ~owner_q;
   assign gnt1      = owned &  owner_q;
   assign ack0      = completing & ~owner_q;
   assign ack1      = completing &  owner_q;
   assign busy      = owned;
   // RAM output is valid in COMPLETE because the address was presented in ACCESS.
   assign rdata     = mem_dout;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;
   assign mem_write = mem_write_q;

endmodule
